// File: rtl/pic_io_pkg.sv
// Shared constants and types for the PIC-style GPIO port.
package pic_io_pkg;

    // Register select encoding seen on reg_sel.
    localparam logic REG_PORT = 1'b0;
    localparam logic REG_TRIS = 1'b1;

    // A TRIS bit of 1 makes the pin an input. Replicate it to WIDTH for the reset value.
    localparam logic TRIS_IN = 1'b1;

    // 10 ms of stable input at 50 MHz.
    localparam int DEB_50MHZ_10MS = 500000;

    // One register access as presented by the core in a single cycle.
    typedef struct packed {
        logic sel;
        logic wr;
        logic rd;
    } reg_req_t;

    // Debounce counter width. It holds values up to DEBOUNCE_CYCLES and is never narrower than 1 bit.
    function automatic int deb_cnt_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pic_gpio_debounce.sv
// Single-pin input path: SYNC_STAGES-deep synchroniser followed by a
// stable-count debouncer. DEBOUNCE_CYCLES = 0 passes the synchronised value
// straight through.
module pic_gpio_debounce
    import pic_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEB_50MHZ_10MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic deb
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    // Shift the raw asynchronous pin through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign deb = sync;
        end else begin : g_count
            localparam int            CW       = deb_cnt_w(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            localparam logic [CW-1:0] CNT_MAX  = '1;

            logic [CW-1:0] cnt;
            logic          deb_q;

            // Count consecutive cycles where sync differs from deb. After enough of them, accept the new level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt   <= '0;
                    deb_q <= 1'b0;
                end else if (sync == deb_q) begin
                    cnt <= '0;
                end else if (cnt >= CNT_LAST) begin
                    deb_q <= sync;
                    cnt   <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign deb = deb_q;
        end
    endgenerate

endmodule

// File: rtl/pic_gpio_port.sv
// Parametrised PIC-style I/O port: PORT/TRIS registers, per-pin
// synchronise+debounce lanes, and a sticky masked interrupt-on-change flag.
module pic_gpio_port
    import pic_io_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = DEB_50MHZ_10MS,
    parameter logic [WIDTH-1:0] IOC_MASK        = WIDTH'(8'hF0)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reg_sel,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic             ioc_enable,
    input  logic             ioc_clear,
    output logic             ioc_flag,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe
);

    localparam logic [WIDTH-1:0] TRIS_RESET = {WIDTH{TRIS_IN}};

    reg_req_t         req;
    logic [WIDTH-1:0] port_latch;
    logic [WIDTH-1:0] tris;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] ioc_ref;
    logic [WIDTH-1:0] port_view;
    logic [WIDTH-1:0] mismatch;

    assign req = '{sel: reg_sel, wr: wr_en, rd: rd_en};

    // One synchroniser/debounce lane per pin.
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_lane
            pic_gpio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .pin   (pin_in[g]),
                .deb   (deb[g])
            );
        end
    endgenerate

    // Input bits show the debounced pin. Output bits show the latch. Only masked input bits can raise IOC.
    assign port_view = (tris & deb) | (~tris & port_latch);
    assign mismatch  = (deb ^ ioc_ref) & IOC_MASK & tris;

    // Register writes. The latch still updates on input bits so the value is ready when TRIS turns the bit into an output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_latch <= '0;
            tris       <= TRIS_RESET;
        end else if (req.wr) begin
            if (req.sel == REG_TRIS) tris       <= wdata;
            else                     port_latch <= wdata;
        end
    end

    // Registered reads return pre-write values. A PORT read also snapshots deb as the new IOC reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata   <= '0;
            ioc_ref <= '0;
        end else if (req.rd) begin
            if (req.sel == REG_TRIS) begin
                rdata <= tris;
            end else begin
                rdata   <= port_view;
                ioc_ref <= deb;
            end
        end
    end

    // Sticky change flag. A new set in the same cycle as a clear wins so that no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         ioc_flag <= 1'b0;
        else if (ioc_enable && |mismatch)   ioc_flag <= 1'b1;
        else if (ioc_clear)                 ioc_flag <= 1'b0;
    end

    assign pin_out = port_latch;
    assign pin_oe  = ~tris;

endmodule

// File: tb/tb_pic_gpio_port.sv
// Scoreboard bench for pic_gpio_port (WIDTH 8, SYNC_STAGES 2, DEBOUNCE_CYCLES 4).
module tb_pic_gpio_port;
    import pic_io_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         reg_sel, wr_en, rd_en;
    logic [W-1:0] wdata, rdata;
    logic         ioc_enable, ioc_clear, ioc_flag;
    logic [W-1:0] pin_in, pin_out, pin_oe;

    pic_gpio_port #(
        .WIDTH           (W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .IOC_MASK        (8'hF0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_sel    (reg_sel),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wdata      (wdata),
        .rdata      (rdata),
        .ioc_enable (ioc_enable),
        .ioc_clear  (ioc_clear),
        .ioc_flag   (ioc_flag),
        .pin_in     (pin_in),
        .pin_out    (pin_out),
        .pin_oe     (pin_oe)
    );

    always #5 clk = ~clk;

    // kind: 0 pin_out, 1 pin_oe, 2 ioc_flag, 3 internal debounced value, 4 read data
    typedef struct {
        string        name;
        int           kind;
        logic [W-1:0] exp;
    } exp_t;

    exp_t st_q[$];
    exp_t rd_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic rd_v   = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input string name, input int kind, input logic [W-1:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        st_q.push_back(e);
    endtask

    task automatic push_rd(input string name, input logic [W-1:0] exp);
        exp_t e;
        e.name = name;
        e.kind = 4;
        e.exp  = exp;
        rd_q.push_back(e);
    endtask

    task automatic wr(input logic sel, input logic [W-1:0] data);
        reg_sel = sel;
        wdata   = data;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic sel, input logic [W-1:0] exp, input string name);
        push_rd(name, exp);
        reg_sel = sel;
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
    endtask

    // Note which edges captured a read.
    always @(posedge clk) rd_v <= rd_en;

    // Monitor: compare read data on the edge after capture and drain any pending output probes.
    always @(negedge clk) begin
        exp_t e;
        if (rd_v) begin
            if (rd_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_q underflow: got rdata %h, expected no read", rdata);
            end else begin
                e = rd_q.pop_front();
                check(e.name, rdata, e.exp);
            end
        end
        while (st_q.size() > 0) begin
            e = st_q.pop_front();
            case (e.kind)
                0:       check(e.name, pin_out, e.exp);
                1:       check(e.name, pin_oe, e.exp);
                2:       check(e.name, {7'b0, ioc_flag}, e.exp);
                default: check(e.name, dut.deb, e.exp);
            endcase
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; reg_sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
        ioc_enable = 1'b0; ioc_clear = 1'b0; pin_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        ex("rst pin_oe", 1, 8'h00);
        ex("rst pin_out", 0, 8'h00);
        ex("rst ioc_flag", 2, 8'h00);
        ex("rst deb", 3, 8'h00);
        rd(REG_TRIS, 8'hFF, "rst tris read");

        // output drive
        wr(REG_TRIS, 8'h0F);
        ex("pin_oe after tris", 1, 8'hF0);
        wr(REG_PORT, 8'hA5);
        ex("pin_out after port", 0, 8'hA5);
        ex("pin_oe hold", 1, 8'hF0);
        rd(REG_PORT, 8'hA0, "port read mixed");

        // 3-cycle glitch on bit0 must be ignored
        pin_in = 8'h01;
        repeat (3) tick();
        pin_in = 8'h00;
        repeat (8) tick();
        rd(REG_PORT, 8'hA0, "glitch ignored");

        // steady level: deb flips on the 6th edge after the pin change
        pin_in = 8'h01;
        repeat (5) tick();
        ex("deb before latency", 3, 8'h00);
        rd(REG_PORT, 8'hA0, "port read edge 6");
        ex("deb at latency", 3, 8'h01);
        rd(REG_PORT, 8'hA1, "port read edge 7");
        pin_in = 8'h00;
        repeat (8) tick();

        // same-cycle write and read of TRIS returns the old value
        push_rd("tris read during write", 8'h0F);
        reg_sel = REG_TRIS; wdata = 8'h3C; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        rd(REG_TRIS, 8'h3C, "tris after write");
        ex("pin_oe new tris", 1, 8'hC3);

        // IOC masking
        wr(REG_TRIS, 8'hFF);
        ioc_enable = 1'b1;
        rd(REG_PORT, 8'h00, "ioc arm read");
        pin_in = 8'h02;
        repeat (8) tick();
        pin_in = 8'h00;
        repeat (8) tick();
        ex("ioc masked bit1", 2, 8'h00);
        pin_in = 8'h20;
        repeat (7) tick();
        ex("ioc set bit5", 2, 8'h01);

        // clear loses against a live mismatch
        ioc_clear = 1'b1;
        tick();
        ioc_clear = 1'b0;
        ex("ioc set wins over clear", 2, 8'h01);
        rd(REG_PORT, 8'h20, "port read bit5 high");
        ioc_clear = 1'b1;
        tick();
        ioc_clear = 1'b0;
        ex("ioc cleared", 2, 8'h00);

        // falling edge sets it again, and it remains set after the mismatch goes away
        pin_in = 8'h00;
        repeat (8) tick();
        ex("ioc falling edge", 2, 8'h01);
        rd(REG_PORT, 8'h00, "port read after fall");
        ex("ioc sticky", 2, 8'h01);
        ioc_clear = 1'b1;
        tick();
        ioc_clear = 1'b0;
        ex("ioc cleared again", 2, 8'h00);

        // output bits never raise IOC
        wr(REG_TRIS, 8'h0F);
        pin_in = 8'h20;
        repeat (8) tick();
        ex("ioc output bit ignored", 2, 8'h00);
        pin_in = 8'h00;
        repeat (8) tick();

        // set up nonzero state, then reset asynchronously mid-debounce
        wr(REG_TRIS, 8'hFF);
        wr(REG_PORT, 8'hFF);
        ex("pin_out all ones", 0, 8'hFF);
        pin_in = 8'h21;
        repeat (8) tick();
        ex("deb 21", 3, 8'h21);
        ex("ioc before reset", 2, 8'h01);
        rd(REG_PORT, 8'h21, "port read before reset");
        pin_in = 8'h00;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async pin_out", pin_out, 8'h00);
        check("async pin_oe", pin_oe, 8'h00);
        check("async ioc_flag", {7'b0, ioc_flag}, 8'h00);
        check("async deb", dut.deb, 8'h00);
        check("async rdata", rdata, 8'h00);

        // full latency after release
        pin_in = 8'h01;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) tick();
        ex("post-reset deb before latency", 3, 8'h00);
        tick();
        ex("post-reset deb at latency", 3, 8'h01);

        repeat (2) tick();
        check("scoreboard drained", W'(rd_q.size() + st_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pic_gpio_port.md
Name: pic_gpio_port

Overview:
- Parametrised PIC-style I/O port for the PIC16F soft core on DE2-115.
- Replaces fixed 8-bit PORTA wiring to KEY/SW/LEDG/LEDR/LCD with a generic N-bit port.
- Per-bit direction (TRIS), output latch, two-flop input synchroniser and per-bit debounce.
- Sticky interrupt-on-change (IOC) flag on masked input bits; the core accesses it through a simple register strobe interface.

Parameters:
- WIDTH, 8, number of port pins.
- SYNC_STAGES, 2, input synchroniser depth (minimum 2).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced input changes; 0 = debounce bypassed.
- IOC_MASK, 8'hF0, bits eligible for interrupt-on-change (WIDTH bits wide).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst_n  in  1  asynchronous active-low reset.
- reg_sel  in  1  0 = PORT register, 1 = TRIS register.
- wr_en  in  1  write strobe, one cycle.
- rd_en  in  1  read strobe, one cycle.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  registered read data.
- ioc_enable  in  1  global IOC enable.
- ioc_clear  in  1  clears ioc_flag.
- ioc_flag  out  1  sticky change-detected flag.
- pin_in  in  WIDTH  raw asynchronous pin inputs (keys, switches).
- pin_out  out  WIDTH  output latch value.
- pin_oe  out  WIDTH  output enable per bit; 1 = drive (equals ~TRIS).

Behaviour:
- Reset (asynchronous, rst_n = 0) values:
  - port_latch = 0; tris = all 1s (all inputs); pin_out = 0; pin_oe = 0.
  - rdata = 0; ioc_flag = 0.
  - Sync chain, debounced value, debounce counters and ioc_ref all 0.
- Reset asserted mid-operation aborts everything immediately: counters clear and a pending set of ioc_flag is lost.
- Writes:
  - wr_en with reg_sel = 0 loads port_latch; with reg_sel = 1 loads tris.
  - Effective on pin_out/pin_oe in the next cycle.
  - Writing PORT while a bit is an input still updates its latch; the value drives once TRIS clears.
- Reads:
  - rdata updates one cycle after rd_en and holds until the next rd_en.
  - PORT read: bit i = tris[i] ? deb[i] : port_latch[i].
  - TRIS read returns tris.
- Same-cycle wr_en and rd_en to the same register: rdata returns the pre-write value.
- Input path: pin_in passes through SYNC_STAGES flops to give sync[i].
- Debounce, per bit:
  - If sync[i] == deb[i], counter = 0.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, deb[i] <= sync[i] and the counter resets.
  - The counter saturates and never wraps.
  - Total latency from a pin edge to deb = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES is ignored.
  - With DEBOUNCE_CYCLES = 0, deb = sync (no counter logic).
- IOC:
  - ioc_ref is loaded with deb on every PORT read, mirroring the PIC "read clears mismatch" rule.
  - mismatch = (deb ^ ioc_ref) & IOC_MASK & tris.
  - If ioc_enable and any mismatch bit is set, ioc_flag <= 1.
  - ioc_clear clears ioc_flag; when set and clear occur in the same cycle, set wins.
  - Output bits (tris = 0) never contribute to mismatch.
  - Flag is sticky: it stays set after the mismatch disappears, until ioc_clear.
- Counter width = clog2(DEBOUNCE_CYCLES+1), minimum 1.

Decomposition:
- Shared package pic_io_pkg holds:
  - REG_PORT = 1'b0 and REG_TRIS = 1'b1.
  - TRIS_RESET (all 1s) replicate helper.
  - Default debounce constant DEB_50MHZ_10MS = 500000.
- Natural sub-module pic_gpio_debounce: single-bit synchroniser plus debounce counter, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES, instantiated WIDTH times via a generate loop.
- Register file, read mux and IOC logic stay in pic_gpio_port.

Test Plan (WIDTH = 8, DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2 unless stated):
- Reset check: after rst_n release, expect pin_oe = 8'h00, pin_out = 8'h00, ioc_flag = 0, and TRIS read returning 8'hFF after 1 cycle.
- Output drive: write TRIS = 8'h0F, then PORT = 8'hA5. Expect pin_oe = 8'hF0 and pin_out = 8'hA5 next cycle. PORT read with pin_in = 8'h00 after settle returns 8'hA0 (low nibble inputs = 0, high nibble latch).
- Debounce: hold pin_in[0] = 1 for 3 cycles then 0 → deb never changes and PORT read bit0 = 0. Hold it at 1 for 7 cycles → bit0 reads 1 exactly SYNC_STAGES + 4 cycles after the edge.
- IOC masking: TRIS = 8'hFF, ioc_enable = 1, read PORT. Toggle pin_in[1] (masked out) → ioc_flag stays 0. Toggle pin_in[5] for 6+ cycles → ioc_flag = 1, and it stays 1 after pin_in[5] returns to 0.
- IOC clear collision: with the mismatch still present (no PORT read), pulse ioc_clear → flag remains 1 (set wins). Read PORT, then ioc_clear → flag = 0.
- Async reset mid-debounce: assert rst_n = 0 while a counter is at 2 → deb, pin_out and ioc_flag are 0 immediately, without waiting for a clk edge. After release, a full SYNC_STAGES + 4 cycles is needed before deb changes.
